player_motion_ctl: RTL and testbench



---
 rtl/player_motion_ctl.sv | 173 +++++++++++++++++
 tb/tb_player_motion_ctl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctl.sv
// Player sprite motion: floor walking, charged jumps (hold space, release to launch), gravity flight.
// Motion advances once per physics tick; key edges are acted on every cycle; outputs lag state by one cycle.
module player_motion_ctl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 64,
    parameter int TICK_CYCLES = 400000,
    parameter int FRAC_BITS   = 4,
    parameter int GRAVITY     = 8,
    parameter int VY_MAX      = 256,
    parameter int WALK_SPEED  = 2,
    parameter int JUMP_VX     = 48,
    parameter int JUMP_V_BASE = 64,
    parameter int JUMP_V_GAIN = 8,
    parameter int MAX_CHARGE  = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_space,
    input  logic        key_left,
    input  logic        key_right,
    output logic [11:0] value_x,
    output logic [11:0] value_y,
    output logic [1:0]  state_out,
    output logic [5:0]  charge_level,
    output logic        airborne
);
    localparam int PW    = 13 + FRAC_BITS;
    localparam int CW    = $clog2(TICK_CYCLES);
    localparam int FLOOR = SCREEN_H - SPRITE_H - 1;
    localparam int XMAX  = SCREEN_W - SPRITE_W;

    localparam logic signed [PW-1:0] FLOOR_SUB = PW'(FLOOR << FRAC_BITS);
    localparam logic signed [PW-1:0] XMAX_SUB  = PW'(XMAX << FRAC_BITS);
    localparam logic signed [PW-1:0] WALK_SUB  = PW'(WALK_SPEED << FRAC_BITS);
    localparam logic signed [15:0]   VY_MAX_V  = 16'(VY_MAX);
    localparam logic signed [15:0]   GRAV_V    = 16'(GRAVITY);
    localparam logic signed [15:0]   JVX_V     = 16'(JUMP_VX);
    localparam logic [15:0]          JVB_V     = 16'(JUMP_V_BASE);
    localparam logic [15:0]          JVG_V     = 16'(JUMP_V_GAIN);
    localparam logic [5:0]           CHG_SAT   = 6'(MAX_CHARGE);
    localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_CHARGE = 2'd1,
        ST_AIR    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [PW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [15:0]    vx_q, vx_d, vy_q, vy_d;
    logic [5:0]            charge_q, charge_d;
    logic                  space_prev_q;
    logic [CW-1:0]         cnt_q;

    logic                  tick, space_rise, space_fall;
    logic signed [PW-1:0]  x_nxt, y_nxt;
    logic signed [15:0]    vy_grav;
    logic [15:0]           launch_v;

    assign tick       = (cnt_q == TICK_LAST);
    assign space_rise = key_space & ~space_prev_q;
    assign space_fall = ~key_space & space_prev_q;
    assign x_nxt      = x_q + PW'(vx_q);
    assign y_nxt      = y_q + PW'(vy_q);
    assign vy_grav    = vy_q + GRAV_V;
    assign launch_v   = JVB_V + 16'(charge_q) * JVG_V;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        charge_d = charge_q;
        case (state_q)
            ST_GROUND: begin
                if (tick) begin
                    if (key_right && !key_left)
                        x_d = (x_q > XMAX_SUB - WALK_SUB) ? XMAX_SUB : x_q + WALK_SUB;
                    else if (key_left && !key_right)
                        x_d = (x_q < WALK_SUB) ? '0 : x_q - WALK_SUB;
                end
                if (space_rise) begin
                    state_d  = ST_CHARGE;
                    charge_d = '0;
                end
            end
            ST_CHARGE: begin
                // A release on a tick cycle launches with the charge held before that tick.
                if (space_fall) begin
                    state_d = ST_AIR;
                    vy_d    = -$signed(launch_v);
                    if (key_right && !key_left)
                        vx_d = JVX_V;
                    else if (key_left && !key_right)
                        vx_d = -JVX_V;
                    else
                        vx_d = '0;
                end else if (tick && charge_q < CHG_SAT) begin
                    charge_d = charge_q + 6'd1;
                end
            end
            ST_AIR: begin
                if (tick) begin
                    if (x_nxt[PW-1]) begin
                        x_d  = '0;
                        vx_d = -(vx_q >>> 1);
                    end else if (x_nxt > XMAX_SUB) begin
                        x_d  = XMAX_SUB;
                        vx_d = -(vx_q >>> 1);
                    end else begin
                        x_d = x_nxt;
                    end
                    // Landing overrides any wall rebound velocity from this same tick.
                    if (y_nxt[PW-1]) begin
                        y_d  = '0;
                        vy_d = '0;
                    end else if (y_nxt >= FLOOR_SUB && !vy_q[15]) begin
                        y_d     = FLOOR_SUB;
                        vx_d    = '0;
                        vy_d    = '0;
                        state_d = ST_GROUND;
                    end else begin
                        y_d  = y_nxt;
                        vy_d = (vy_grav > VY_MAX_V) ? VY_MAX_V : vy_grav;
                    end
                end
            end
            default: state_d = ST_GROUND;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_GROUND;
            x_q          <= '0;
            y_q          <= FLOOR_SUB;
            vx_q         <= '0;
            vy_q         <= '0;
            charge_q     <= '0;
            space_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            charge_q     <= charge_d;
            space_prev_q <= key_space;
            cnt_q        <= tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_x      <= '0;
            value_y      <= 12'(FLOOR);
            state_out    <= ST_GROUND;
            charge_level <= '0;
            airborne     <= 1'b0;
        end else begin
            value_x      <= 12'(x_q >>> FRAC_BITS);
            value_y      <= 12'(y_q >>> FRAC_BITS);
            state_out    <= state_q;
            charge_level <= charge_q;
            airborne     <= (state_q == ST_AIR);
        end
    end
endmodule

// File: tb/tb_player_motion_ctl.sv
// Bench for player_motion_ctl with a 4-cycle tick: scenario tasks plus a randomized run,
// all compared against an integer subpixel model of the motion rules.
module tb_player_motion_ctl;
    localparam int T      = 4;
    localparam int SUB    = 16;
    localparam int FLOOR  = 535;
    localparam int XMAX   = 736;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_space = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic [11:0] value_x, value_y;
    logic [1:0]  state_out;
    logic [5:0]  charge_level;
    logic        airborne;
    logic [32:0] dut_vec;

    int checks = 0;
    int fails  = 0;

    // Model state in subpixels; e_* are the outputs expected after the most recent edge.
    int mx, my, mvx, mvy, mst, mch, mprev, mcnt, mair;
    int e_x, e_y, e_st, e_ch, e_air;

    player_motion_ctl #(.TICK_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .key_space(key_space), .key_left(key_left),
        .key_right(key_right), .value_x(value_x), .value_y(value_y),
        .state_out(state_out), .charge_level(charge_level), .airborne(airborne)
    );

    always #5 clk = ~clk;
    assign dut_vec = {value_x, value_y, state_out, charge_level, airborne};

    function automatic logic [32:0] exp_vec();
        return {12'(e_x), 12'(e_y), 2'(e_st), 6'(e_ch), 1'(e_air)};
    endfunction

    function automatic int half_floor(int v);
        return (v < 0) ? -((-v + 1) / 2) : v / 2;
    endfunction

    task automatic model_reset();
        mx = 0; my = FLOOR * SUB; mvx = 0; mvy = 0; mst = 0; mch = 0;
        mprev = 0; mcnt = 0; mair = 0;
        e_x = 0; e_y = FLOOR; e_st = 0; e_ch = 0; e_air = 0;
    endtask

    task automatic model_edge();
        bit tick, rise, fall;
        int nx, ny;
        e_x = mx / SUB; e_y = my / SUB; e_st = mst; e_ch = mch; e_air = (mst == 2);
        tick = (mcnt == T - 1);
        mcnt = tick ? 0 : mcnt + 1;
        rise = key_space && !mprev;
        fall = !key_space && mprev;
        mprev = key_space;
        if (mst == 0) begin
            if (tick && key_right && !key_left) mx = (mx + 2 * SUB > XMAX * SUB) ? XMAX * SUB : mx + 2 * SUB;
            if (tick && key_left && !key_right) mx = (mx - 2 * SUB < 0) ? 0 : mx - 2 * SUB;
            if (rise) begin mst = 1; mch = 0; end
        end else if (mst == 1) begin
            if (fall) begin
                mst = 2; mair = 0;
                mvy = -(64 + mch * 8);
                mvx = (key_right && !key_left) ? 48 : (key_left && !key_right) ? -48 : 0;
            end else if (tick && mch < 24) begin
                mch = mch + 1;
            end
        end else if (tick) begin
            mair++;
            nx = mx + mvx;
            if (nx < 0) begin mx = 0; mvx = -half_floor(mvx); end
            else if (nx > XMAX * SUB) begin mx = XMAX * SUB; mvx = -half_floor(mvx); end
            else mx = nx;
            ny = my + mvy;
            if (ny < 0) begin my = 0; mvy = 0; end
            else if (ny >= FLOOR * SUB && mvy >= 0) begin my = FLOOR * SUB; mvx = 0; mvy = 0; mst = 0; end
            else begin my = ny; mvy = (mvy + 8 > 256) ? 256 : mvy + 8; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) step();
        checks++;
        if (value_x !== 12'd0 || value_y !== 12'd535) begin
            fails++; $display("FAIL reset_pos: got x=%0d y=%0d, need x=0 y=535", value_x, value_y);
        end
        checks++;
        if (state_out !== 2'd0 || airborne !== 1'b0 || charge_level !== 6'd0) begin
            fails++; $display("FAIL reset_ctl: got st=%0d air=%0d ch=%0d, need 0 0 0", state_out, airborne, charge_level);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL reset_release: got %h need %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_walk();
        key_right = 1'b1;
        repeat (10 * T) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL walk_right_cycle: got %h need %h", dut_vec, exp_vec());
            end
        end
        key_right = 1'b0;
        repeat (2) step();
        checks++;
        if (value_x !== 12'd20) begin fails++; $display("FAIL walk_right: got x=%0d need 20", value_x); end
        key_left = 1'b1; key_right = 1'b1;
        repeat (5 * T) step();
        key_left = 1'b0; key_right = 1'b0;
        repeat (2) step();
        checks++;
        if (value_x !== 12'd20) begin fails++; $display("FAIL walk_both: got x=%0d need 20", value_x); end
        key_left = 1'b1;
        repeat (20 * T) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL walk_left_cycle: got %h need %h", dut_vec, exp_vec());
            end
        end
        key_left = 1'b0;
        repeat (2) step();
        checks++;
        if (value_x !== 12'd0) begin fails++; $display("FAIL walk_left_clamp: got x=%0d need 0", value_x); end
    endtask

    task automatic wait_landing(input string name);
        int n = 0;
        while (mst != 0 && n < 3000) begin
            step(); n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL %s_flight: got %h need %h", name, dut_vec, exp_vec());
            end
        end
        if (mst != 0) begin fails++; $display("FAIL %s_timeout: still airborne after %0d cycles", name, n); end
        step();
    endtask

    task automatic test_charge_saturation();
        int n = 0;
        key_space = 1'b1;
        repeat (30 * T) step();
        checks++;
        if (charge_level !== 6'd24) begin fails++; $display("FAIL charge_sat: got %0d need 24", charge_level); end
        key_right = 1'b1; key_space = 1'b0;
        repeat (2) step();
        checks++;
        if (airborne !== 1'b1 || state_out !== 2'd2 || charge_level !== 6'd24) begin
            fails++; $display("FAIL launch: got air=%0d st=%0d ch=%0d need 1 2 24", airborne, state_out, charge_level);
        end
        while (mair == 0 && n < 10) begin step(); n++; end
        step();
        checks++;
        if (value_x !== 12'd3 || value_y !== 12'd519) begin
            fails++; $display("FAIL first_air_tick: got x=%0d y=%0d need x=3 y=519", value_x, value_y);
        end
        wait_landing("charge");
        key_right = 1'b0;
        checks++;
        if (state_out !== 2'd0 || value_y !== 12'd535) begin
            fails++; $display("FAIL charge_land: got st=%0d y=%0d need 0 535", state_out, value_y);
        end
    endtask

    task automatic test_tap_jump();
        int x0 = mx / SUB;
        int n = 0;
        key_space = 1'b1; step();
        key_space = 1'b0; step();
        while (mair < 8 && n < 100) begin step(); n++; end
        step();
        checks++;
        if (value_y !== 12'd517 || charge_level !== 6'd0) begin
            fails++; $display("FAIL tap_apex: got y=%0d ch=%0d need y=517 ch=0", value_y, charge_level);
        end
        wait_landing("tap");
        checks++;
        if (state_out !== 2'd0 || value_y !== 12'd535 || value_x !== 12'(x0)) begin
            fails++; $display("FAIL tap_land: got st=%0d y=%0d x=%0d need 0 535 %0d", state_out, value_y, value_x, x0);
        end
    endtask

    task automatic test_wall_rebound();
        int n = 0;
        int max_x = 0;
        key_left = 1'b1;
        while (mx != 0 && n < 4000) begin step(); n++; end
        key_left = 1'b0; key_right = 1'b1; n = 0;
        while (mx != 700 * SUB && n < 4000) begin step(); n++; end
        key_right = 1'b0;
        step();
        checks++;
        if (value_x !== 12'd700) begin fails++; $display("FAIL wall_start: got x=%0d need 700", value_x); end
        key_space = 1'b1;
        repeat (30 * T) step();
        key_right = 1'b1; key_space = 1'b0;
        n = 0;
        while ((mst != 0 || n == 0) && n < 3000) begin
            step(); n++;
            if (value_x > 12'(max_x)) max_x = value_x;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL wall_flight: got %h need %h", dut_vec, exp_vec());
            end
        end
        step();
        key_right = 1'b0;
        checks++;
        if (max_x != XMAX) begin fails++; $display("FAIL wall_peak_x: got %0d need 736", max_x); end
        checks++;
        if (value_x >= 12'd736 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL wall_land: got %h need %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_air();
        int n = 0;
        key_space = 1'b1; step();
        key_space = 1'b0; step();
        while (mair < 2 && n < 100) begin step(); n++; end
        @(negedge clk); #2 rst = 1'b1; #1;
        model_reset();
        checks++;
        if (value_y !== 12'd535 || airborne !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL async_reset: got %h need %h", dut_vec, exp_vec());
        end
        key_right = 1'b1;
        repeat (3 * T) step();
        checks++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_hold: got %h need %h", dut_vec, exp_vec()); end
        key_right = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (2) step();
        checks++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_rerelease: got %h need %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 29) == 0) key_space = ~key_space;
            if ($urandom_range(0, 7) == 0) key_left = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) key_right = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL random_cycle %0d: got %h need %h", i, dut_vec, exp_vec());
            end
        end
        key_space = 1'b0; key_left = 1'b0; key_right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_charge_saturation();
        test_tap_jump();
        test_wall_rebound();
        test_reset_mid_air();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
